// File: rtl/bht_update_unit_pkg.sv
// bht_update_unit_pkg: shared 2-bit counter encodings for the branch history table
package bht_update_unit_pkg;

    typedef enum logic [1:0] {
        ST_SNT = 2'b00,
        ST_WNT = 2'b01,
        ST_WT  = 2'b10,
        ST_ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = ST_WNT;

endpackage

// File: rtl/bht_update_unit_counter_next.sv
// bht_counter_next: 2-bit saturating counter step toward the resolved outcome
module bht_counter_next
    import bht_update_unit_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    assign next_state = taken ? ((state == ST_ST)  ? ST_ST  : state + 2'd1)
                              : ((state == ST_SNT) ? ST_SNT : state - 2'd1);

endmodule

// File: rtl/bht_update_unit.sv
// bht_update_unit: branch history table with same-cycle bypass, mispredict flag and statistics
module bht_update_unit
    import bht_update_unit_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int PC_W    = 32,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              tbl_clr,
    input  logic [PC_W-1:0]   pred_pc,
    output logic [1:0]        pred_state,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [1:0]        upd_state_in,
    input  logic              upd_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [1:0]         tbl [DEPTH];
    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [1:0]         next_state;
    logic               do_write;
    logic               unused_pc_bits;

    // Word-aligned PCs: the low two bits and the bits above the index never select an entry
    assign pred_idx       = pred_pc[INDEX_W+1:2];
    assign upd_idx        = upd_pc[INDEX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:INDEX_W+2], pred_pc[1:0],
                              upd_pc[PC_W-1:INDEX_W+2], upd_pc[1:0]};

    assign do_write   = en & upd_valid & ~tbl_clr;
    assign mispredict = upd_valid & (upd_state_in[1] != upd_taken);

    // Next state comes from the fetch-time snapshot, not a table re-read
    bht_counter_next u_next (
        .state      (upd_state_in),
        .taken      (upd_taken),
        .next_state (next_state)
    );

    // Fetch sees the value being written this cycle when both index the same entry
    always_comb begin
        pred_state = (do_write && pred_idx == upd_idx) ? next_state : tbl[pred_idx];
        pred_taken = pred_state[1];
    end

    // Counter table: reset and clear return every entry to weak-not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_RESET;
        end else if (tbl_clr) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_RESET;
        end else if (do_write) begin
            tbl[upd_idx] <= next_state;
        end
    end

    // Saturating statistics for resolved branches and mispredictions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (tbl_clr) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (do_write) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
            if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_bht_update_unit.sv
// tb_bht_update_unit: directed checks of prediction, update, bypass, stall, clear and reset
module tb_bht_update_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tbl_clr;
    logic [31:0] pred_pc;
    logic [1:0]  pred_state;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_state_in;
    logic        upd_taken;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int errors = 0;
    int checks = 0;

    bht_update_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .tbl_clr          (tbl_clr),
        .pred_pc          (pred_pc),
        .pred_state       (pred_state),
        .pred_taken       (pred_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_state_in     (upd_state_in),
        .upd_taken        (upd_taken),
        .mispredict       (mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] st, input logic tk);
        upd_valid    = v;
        upd_pc       = pc;
        upd_state_in = st;
        upd_taken    = tk;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; tbl_clr = 1'b0; pred_pc = 32'h1234;
        drive(1'b0, 32'h0, 2'b00, 1'b0);
        #12;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL reset_pred_state got=%b exp=01", pred_state); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_update;
        @(negedge clk);
        pred_pc = 32'h40;
        drive(1'b1, 32'h40, 2'b01, 1'b1);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL upd_mispredict got=%b exp=1", mispredict); end
        step;
        checks++; if (pred_state !== 2'b10 || pred_taken !== 1'b1) begin
            errors++; $display("FAIL upd_entry16 got=%b/%b exp=10/1", pred_state, pred_taken); end
        checks++; if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
            errors++; $display("FAIL upd_stats got=%0d/%0d exp=1/1", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        pred_pc = 32'h80;
        drive(1'b1, 32'h80, 2'b11, 1'b1);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_hi_mispredict got=%b exp=0", mispredict); end
        step;
        checks++; if (pred_state !== 2'b11) begin errors++; $display("FAIL sat_hi_entry got=%b exp=11", pred_state); end
        @(negedge clk);
        drive(1'b1, 32'h80, 2'b00, 1'b0);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_lo_mispredict got=%b exp=0", mispredict); end
        step;
        checks++; if (pred_state !== 2'b00) begin errors++; $display("FAIL sat_lo_entry got=%b exp=00", pred_state); end
        checks++; if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1) begin
            errors++; $display("FAIL sat_stats got=%0d/%0d exp=3/1", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        pred_pc = 32'h100;
        drive(1'b1, 32'h100, 2'b10, 1'b1);
        step;
        checks++; if (pred_state !== 2'b11) begin errors++; $display("FAIL byp_setup got=%b exp=11", pred_state); end
        @(negedge clk);
        drive(1'b1, 32'h100, 2'b10, 1'b0);
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL byp_same_idx got=%b exp=01", pred_state); end
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL byp_mispredict got=%b exp=1", mispredict); end
        pred_pc = 32'h104;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL byp_other_idx got=%b exp=01", pred_state); end
        pred_pc = 32'h100;
        step;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL byp_written got=%b exp=01", pred_state); end
        checks++; if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            errors++; $display("FAIL byp_stats got=%0d/%0d exp=5/2", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        en = 1'b0;
        pred_pc = 32'h20;
        drive(1'b1, 32'h20, 2'b10, 1'b0);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL stall_mispredict got=%b exp=1", mispredict); end
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL stall_no_bypass got=%b exp=01", pred_state); end
        step;
        en = 1'b1;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL stall_entry8 got=%b exp=01", pred_state); end
        checks++; if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            errors++; $display("FAIL stall_stats got=%0d/%0d exp=5/2", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        pred_pc = 32'h40;
        drive(1'b1, 32'h40, 2'b00, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 32'h40, 2'b11, 1'b0);
        #1;
        checks++; if (pred_state !== 2'b10) begin errors++; $display("FAIL b2b_bypass got=%b exp=10", pred_state); end
        step;
        checks++; if (pred_state !== 2'b10) begin errors++; $display("FAIL b2b_last_writer got=%b exp=10", pred_state); end
        checks++; if (stat_branches !== 32'd7 || stat_mispredicts !== 32'd4) begin
            errors++; $display("FAIL b2b_stats got=%0d/%0d exp=7/4", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_clear;
        @(negedge clk);
        en = 1'b0;
        tbl_clr = 1'b1;
        pred_pc = 32'h80;
        drive(1'b1, 32'h80, 2'b11, 1'b1);
        #1;
        checks++; if (pred_state !== 2'b00) begin errors++; $display("FAIL clr_no_bypass got=%b exp=00", pred_state); end
        step;
        tbl_clr = 1'b0; en = 1'b1;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL clr_entry32 got=%b exp=01", pred_state); end
        pred_pc = 32'h40;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL clr_entry16 got=%b exp=01", pred_state); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++; $display("FAIL clr_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        pred_pc = 32'h80;
        drive(1'b1, 32'h80, 2'b01, 1'b1);
        step;
        checks++; if (pred_state !== 2'b10 || stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
            errors++; $display("FAIL arst_setup got=%b %0d/%0d exp=10 1/1", pred_state, stat_branches, stat_mispredicts); end
        @(negedge clk);
        drive(1'b1, 32'h40, 2'b01, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL arst_immediate got=%b exp=01", pred_state); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++; $display("FAIL arst_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 1'b0);
        rst_n = 1'b1;
        pred_pc = 32'h40;
        #1;
        checks++; if (pred_state !== 2'b01) begin errors++; $display("FAIL arst_no_write got=%b exp=01", pred_state); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++; $display("FAIL arst_stats_held got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    endtask

    initial begin
        test_reset;
        test_update;
        test_saturation;
        test_bypass;
        test_stall;
        test_back_to_back;
        test_clear;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
